// File: rtl/data_mem_responder.sv
// data_mem_responder: unified word memory with fixed-latency Busy/Done data port and combinational fetch port
// Optional feature: define MEM_ERR_CHECK_EN to discard/zero out-of-range data accesses and report them on Err.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_wr;
    logic                r_oor;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [2**ADDR_W];

    logic                w_oor;
    logic                w_fire;
    logic                w_commit;
    logic [31:0]         w_rdata;
    logic                w_unused;

`ifdef MEM_ERR_CHECK_EN
    assign w_oor = |Address[31:ADDR_W+2];
`else
    assign w_oor = 1'b0;
`endif

    assign w_fire      = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_commit    = rst && w_fire && r_wr && !r_oor;
    assign w_rdata     = r_oor ? 32'd0 : r_mem[r_idx];
    assign Instruction = r_mem[PC[ADDR_W+1:2]];
    assign w_unused    = &{1'b0, PC[1:0], PC[31:ADDR_W+2], Address[1:0], Address[31:ADDR_W+2]};

    // Request FSM: accept in IDLE, count down in WAIT, pulse Done in RESP
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_oor     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            Read_data <= 32'd0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    Done <= 1'b0;
                    Err  <= 1'b0;
                    if (MemRead || MemWrite) begin
                        r_wr    <= MemWrite;
                        r_oor   <= w_oor;
                        r_idx   <= Address[ADDR_W+1:2];
                        r_wdata <= Write_data;
                        r_cnt   <= 4'(LATENCY - 1);
                        Busy    <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Err     <= r_oor;
                        if (!r_wr)
                            Read_data <= w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    Done    <= 1'b0;
                    Err     <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store commit on the response edge; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_commit)
            r_mem[r_idx] <= r_wdata;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC = 32'd0;
    logic [31:0] Instruction;
    logic [31:0] Address = 32'd0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Write_data = 32'd0;
    logic [31:0] Read_data;
    logic        Busy;
    logic        Done;
    logic        Err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

`ifdef MEM_ERR_CHECK_EN
    localparam logic        OOR_ERR   = 1'b1;
    localparam logic [31:0] OOR_MEM0  = 32'h0000_0077;
    localparam logic [31:0] OOR_LOAD  = 32'd0;
`else
    localparam logic        OOR_ERR   = 1'b0;
    localparam logic [31:0] OOR_MEM0  = 32'h0000_CAFE;
    localparam logic [31:0] OOR_LOAD  = 32'h0000_CAFE;
`endif

    data_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .PC(PC), .Instruction(Instruction),
        .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Read_data(Read_data),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got Done=1 expected no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", Read_data, e.rdata);
                chk("err", {31'd0, Err}, {31'd0, e.err});
                chk("busy_at_done", {31'd0, Busy}, 32'd0);
            end
        end else if (rst) begin
            chk("err_idle", {31'd0, Err}, 32'd0);
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!Done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, LAT);
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Address = a; Write_data = d;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        chk("busy_accept", {31'd0, Busy}, 32'd1);
        wait_done();
        @(posedge clk); #1;
    endtask

    task automatic fetch(input string nm, input logic [31:0] pc, input logic [31:0] exp);
        PC = pc; #1;
        chk(nm, Instruction, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_err", {31'd0, Err}, 32'd0);
        chk("rst_rdata", Read_data, 32'd0);
        rst = 1'b1;

        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        fetch("fetch_10", 32'h10, 32'hDEADBEEF);
        req(1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        req(1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF, 1'b0);
        req(1'b1, 1'b0, 32'h20, 32'd0, 32'h12345678, 1'b0);

        req(1'b0, 1'b1, 32'h18, 32'h66666666, 32'h12345678, 1'b0);
        @(negedge clk);
        MemWrite = 1'b1; Address = 32'h14; Write_data = 32'h1;
        sb.push_back('{rdata: 32'h12345678, err: 1'b0});
        @(posedge clk); #1;
        Address = 32'h18; Write_data = 32'h2;
        wait_done();
        MemWrite = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        fetch("fetch_14", 32'h14, 32'h1);
        fetch("fetch_18_kept", 32'h18, 32'h66666666);

        req(1'b0, 1'b1, 32'h30, 32'h30303030, 32'h12345678, 1'b0);
        @(negedge clk);
        MemWrite = 1'b1; Address = 32'h30; Write_data = 32'hAAAA5555;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        chk("abort_err", {31'd0, Err}, 32'd0);
        chk("abort_rdata", Read_data, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        fetch("fetch_30_kept", 32'h30, 32'h30303030);

        req(1'b0, 1'b1, 32'h0, 32'h77, 32'd0, 1'b0);
        req(1'b0, 1'b1, 32'h400, 32'hCAFE, 32'd0, OOR_ERR);
        fetch("fetch_0_oor", 32'h0, OOR_MEM0);
        req(1'b1, 1'b0, 32'h400, 32'd0, OOR_LOAD, OOR_ERR);
        req(1'b1, 1'b0, 32'h14, 32'd0, 32'h1, 1'b0);

        repeat (4) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
